// File: rtl/demux_seq.sv
// Serial bit demultiplexer: routes d into one of eight registered lanes, either
// by explicit lane select or by an auto-incrementing eight-lane capture sequence.
module demux_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic [2:0] s,
  input  logic       En,
  input  logic       mode,
  input  logic       start,
  output logic [7:0] o,
  output logic [2:0] idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] o_reg, o_next;
  logic [2:0] idx_reg, idx_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;

  logic       write_en;
  logic [2:0] write_sel;
  logic       clear_o;
  logic [7:0] lane_we;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    write_en   = 1'b0;
    write_sel  = s;
    clear_o    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!mode) begin
          write_en = En;
        end else if (start) begin
          // The start cycle only arms the capture; its d is not stored.
          state_next = CAPTURE;
          idx_next   = 3'd0;
          clear_o    = 1'b1;
        end
      end
      CAPTURE: begin
        write_sel = idx_reg;
        if (start) begin
          err_next = 1'b1;
        end
        if (En) begin
          write_en = 1'b1;
          idx_next = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == CAPTURE);
    done_next = (state_next == DONE);
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign lane_we[gi] = write_en && (write_sel == 3'(gi));
    assign o_next[gi]  = clear_o ? 1'b0 : (lane_we[gi] ? d : o_reg[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      o_reg     <= 8'h00;
      idx_reg   <= 3'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      o_reg     <= o_next;
      idx_reg   <= idx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign o    = o_reg;
  assign idx  = idx_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_demux_seq.sv
// Self-checking bench for demux_seq: directed scenarios plus randomized traffic
// compared against a behavioural model of the lane-routing rules.
module tb_demux_seq;

  logic       clk;
  logic       rst;
  logic       d;
  logic [2:0] s;
  logic       En;
  logic       mode;
  logic       start;
  logic [7:0] o;
  logic [2:0] idx;
  logic       busy;
  logic       done;
  logic       err;

  int vectors;
  int miscompares;

  // Behavioural model: capture progress tracked as a count of lanes written.
  logic [7:0] m_o;
  int         m_count;
  bit         m_capturing;
  bit         m_done;
  bit         m_err;

  demux_seq dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .s     (s),
    .En    (En),
    .mode  (mode),
    .start (start),
    .o     (o),
    .idx   (idx),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] model_vec();
    return {m_o, 3'(m_count), logic'(m_capturing), logic'(m_done), logic'(m_err)};
  endfunction

  task automatic model_edge(input logic r, input logic dd, input logic [2:0] ss,
                            input logic ee, input logic mm, input logic st);
    if (r) begin
      m_o = 8'h00; m_count = 0; m_capturing = 0; m_done = 0; m_err = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_capturing) begin
      if (st) m_err = 1;
      if (ee) begin
        m_o[m_count] = dd;
        m_count = m_count + 1;
        if (m_count == 8) begin
          m_count = 0;
          m_capturing = 0;
          m_done = 1;
        end
      end
    end else if (!mm) begin
      if (ee) m_o[ss] = dd;
    end else if (st) begin
      m_capturing = 1;
      m_count = 0;
      m_o = 8'h00;
    end
  endtask

  task automatic tick(input logic r, input logic dd, input logic [2:0] ss,
                      input logic ee, input logic mm, input logic st);
    rst = r; d = dd; s = ss; En = ee; mode = mm; start = st;
    @(posedge clk);
    model_edge(r, dd, ss, ee, mm, st);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++;
      if ({o, idx, busy, done, err} !== 14'h0) begin
        miscompares++;
        $display("FAIL reset: got o=%h idx=%0d busy=%b done=%b err=%b, want all zero",
                 o, idx, busy, done, err);
      end
    end
    $display("test_reset: o=%h idx=%0d busy=%b done=%b err=%b", o, idx, busy, done, err);
  endtask

  task automatic test_addressed();
    logic [7:0] want [3];
    want[0] = 8'h08; want[1] = 8'h48; want[2] = 8'h48;
    tick(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (o !== want[0]) begin
      miscompares++; $display("FAIL addr_s3: got o=%h want %h", o, want[0]);
    end
    tick(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (o !== want[1]) begin
      miscompares++; $display("FAIL addr_s6: got o=%h want %h", o, want[1]);
    end
    tick(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (o !== want[2]) begin
      miscompares++; $display("FAIL addr_hold: got o=%h want %h", o, want[2]);
    end
    // start must be ignored while addressed
    tick(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({o, busy} !== {8'h48, 1'b0}) begin
      miscompares++; $display("FAIL addr_start_ignored: got o=%h busy=%b want o=48 busy=0", o, busy);
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'($urandom), 3'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      vectors++;
      if ({o, idx, busy, done, err} !== model_vec()) begin
        miscompares++;
        $display("FAIL addr_random[%0d]: got %h want %h", i, {o, idx, busy, done, err}, model_vec());
      end
    end
    $display("test_addressed: final o=%h", o);
  endtask

  // Runs one eight-lane capture of pat; optional stall after lane 4 and start pulse at lane 2.
  task automatic run_capture(input logic [7:0] pat, input bit stall, input bit pulse,
                             input string name);
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0; done_cnt = 0;
    tick(1'b0, 1'b1, 3'($urandom), 1'b1, 1'b1, 1'b1);
    if (busy) busy_cnt++;
    vectors++;
    if ({o, idx, busy} !== {8'h00, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s_start: got o=%h idx=%0d busy=%b want o=00 idx=0 busy=1", name, o, idx, busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, pat[i], 3'($urandom), 1'b1, 1'($urandom), (pulse && i == 2) ? 1'b1 : 1'b0);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      vectors++;
      if ({o, idx, busy, done, err} !== model_vec()) begin
        miscompares++;
        $display("FAIL %s_lane%0d: got %h want %h", name, i, {o, idx, busy, done, err}, model_vec());
      end
      if (stall && i == 4) begin
        for (int k = 0; k < 3; k++) begin
          tick(1'b0, 1'($urandom), 3'($urandom), 1'b0, 1'($urandom), 1'b0);
          if (busy) busy_cnt++;
          if (done) done_cnt++;
          vectors++;
          if ({idx, o[7:5]} !== {3'd5, 3'b000}) begin
            miscompares++;
            $display("FAIL %s_stall%0d: got idx=%0d o=%h want idx=5 upper lanes clear", name, k, idx, o);
          end
        end
      end
    end
    // DONE cycle: start and En must be ignored
    tick(1'b0, 1'b1, 3'($urandom), 1'b1, 1'b1, 1'b1);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    vectors++;
    if (busy_cnt !== (stall ? 11 : 8)) begin
      miscompares++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cnt, stall ? 11 : 8);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt);
    end
    vectors++;
    if ({o, busy, done, err} !== {pat, 1'b0, 1'b0, logic'(pulse)}) begin
      miscompares++;
      $display("FAIL %s_final: got o=%h busy=%b done=%b err=%b want o=%h busy=0 done=0 err=%b",
               name, o, busy, done, err, pat, pulse);
    end
    $display("%s: o=%h busy_cycles=%0d done_pulses=%0d err=%b", name, o, busy_cnt, done_cnt, err);
  endtask

  task automatic test_capture();
    run_capture(8'h4D, 1'b0, 1'b0, "test_capture");
  endtask

  task automatic test_stall();
    run_capture(8'h4D, 1'b1, 1'b0, "test_stall");
  endtask

  task automatic test_start_while_busy();
    run_capture(8'h4D, 1'b0, 1'b1, "test_start_while_busy");
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if ({idx, busy} !== {3'd5, 1'b1}) begin
      miscompares++; $display("FAIL rst_mid_pre: got idx=%0d busy=%b want idx=5 busy=1", idx, busy);
    end
    tick(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({o, idx, busy, done, err} !== 14'h0) begin
      miscompares++;
      $display("FAIL rst_mid: got o=%h idx=%0d busy=%b done=%b err=%b want all zero",
               o, idx, busy, done, err);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 3'($urandom), 1'b1, 1'b1, 1'b0);
      if (done) done_cnt++;
    end
    vectors++;
    if (done_cnt !== 0) begin
      miscompares++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt);
    end
    $display("test_reset_mid: o=%h idx=%0d err=%b done_pulses=%0d", o, idx, err, done_cnt);
  endtask

  task automatic test_simultaneous_start();
    tick(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (o !== 8'h80) begin
      miscompares++; $display("FAIL simul_pre: got o=%h want 80", o);
    end
    tick(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({o, idx, busy} !== {8'h00, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL simul_start: got o=%h idx=%0d busy=%b want o=00 idx=0 busy=1", o, idx, busy);
    end
    tick(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({o, idx} !== {8'h01, 3'd1}) begin
      miscompares++; $display("FAIL simul_first: got o=%h idx=%0d want o=01 idx=1", o, idx);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'($urandom), 3'($urandom), 1'b1, 1'($urandom), 1'b0);
      vectors++;
      if ({o, idx, busy, done, err} !== model_vec()) begin
        miscompares++;
        $display("FAIL simul_tail[%0d]: got %h want %h", i, {o, idx, busy, done, err}, model_vec());
      end
    end
    $display("test_simultaneous_start: o=%h", o);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(99) < 3) ? 1'b1 : 1'b0, 1'($urandom), 3'($urandom),
           ($urandom_range(99) < 70) ? 1'b1 : 1'b0, 1'($urandom),
           ($urandom_range(99) < 20) ? 1'b1 : 1'b0);
      vectors++;
      if ({o, idx, busy, done, err} !== model_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, {o, idx, busy, done, err}, model_vec());
      end
    end
    $display("test_random: 600 cycles, final o=%h err=%b", o, err);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_o = 8'h00; m_count = 0; m_capturing = 0; m_done = 0; m_err = 0;
    rst = 1'b1; d = 1'b0; s = 3'd0; En = 1'b0; mode = 1'b0; start = 1'b0;
    test_reset();
    test_addressed();
    test_capture();
    test_stall();
    test_start_while_busy();
    test_reset_mid();
    test_simultaneous_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_seq.md
DEMUX_SEQ -- requirements
Module: demux_seq

Interface
REQ-001 Ports SHALL be, clock and reset first:
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 d  input  1  serial data bit to route.
REQ-005 s  input  3  lane select, addressed mode only.
REQ-006 En  input  1  write/advance enable; 0 stalls, no lane written.
REQ-007 mode  input  1  0 = addressed, 1 = sequential capture; sampled only in IDLE.
REQ-008 start  input  1  single-cycle request to begin sequential capture.
REQ-009 o  output  8  registered lane outputs.
REQ-010 idx  output  3  current capture lane pointer.
REQ-011 busy  output  1  high while in CAPTURE.
REQ-012 done  output  1  one-cycle pulse after the 8th lane is captured.
REQ-013 err  output  1  sticky flag for start received while busy.
REQ-014 All outputs SHALL be driven directly from registers; there are no combinational input-to-output paths.

Function
REQ-015 The FSM SHALL have the states IDLE, CAPTURE and DONE.
REQ-016 In IDLE with mode=0 and En=1, o[s] SHALL take d at the next edge, and all other o bits SHALL hold.
REQ-017 When En=0, o SHALL hold its value; it never goes unknown.
REQ-018 In IDLE with mode=1 and start=1, the block SHALL go to CAPTURE, set idx to 0, and clear o to 8'h00. d is not captured that cycle.
REQ-019 In IDLE with mode=1 and start=0, En SHALL be ignored and o SHALL hold.
REQ-020 In IDLE with mode=0, start SHALL be ignored.
REQ-021 In CAPTURE with En=1, o[idx] SHALL take d and idx SHALL increment by 1.
REQ-022 In CAPTURE with En=0, o and idx SHALL hold (stall); there is no timeout.
REQ-023 In CAPTURE with idx=7 and En=1, the block SHALL write o[7], wrap idx to 0, and go to DONE.
REQ-024 In CAPTURE, s and mode SHALL be ignored.
REQ-025 busy SHALL be 1 exactly while the state is CAPTURE.
REQ-026 done SHALL be 1 exactly while the state is DONE, which lasts one cycle; the block then returns to IDLE unconditionally.
REQ-027 In DONE, all inputs SHALL be ignored, including start (which does not set err) and En (which writes nothing).
REQ-028 A start seen in CAPTURE SHALL set err to 1, and capture SHALL continue unaffected.
REQ-029 err SHALL clear only on rst.
REQ-030 Write latency SHALL be one cycle: a write accepted at edge N is visible on o after edge N.
REQ-031 o SHALL hold its final byte after DONE until the next write or reset.

Reset
REQ-032 rst=1 at an edge SHALL force: state IDLE, o=8'h00, idx=0, busy=0, done=0, err=0.
REQ-033 rst SHALL take priority over every other input, including in mid-CAPTURE and in DONE.
REQ-034 A capture aborted by reset SHALL produce no done pulse.

Verification
REQ-035 Addressed write: mode=0, En=1, with (s=3, d=1) then (s=6, d=1) -> o=8'h08, then o=8'h48. Then En=0, s=3, d=0 -> o stays 8'h48.
REQ-036 Sequential capture: mode=1, start pulse, then 8 cycles of En=1 with d=1,0,1,1,0,0,1,0 (lane 0 first) -> o=8'h4D. busy=1 for 8 cycles, done=1 for exactly one cycle, then IDLE.
REQ-037 Stall: same stream as REQ-036 with En=0 for 3 cycles after lane 4 -> o=8'h4D, busy=1 for 11 cycles, idx holds at 5 during the stall.
REQ-038 Start while busy: a start pulse at lane 2 during capture -> err=1 and stays 1 after done. The final o is unchanged from the no-pulse case.
REQ-039 Reset mid-operation: rst at idx=5 during capture -> o=8'h00, idx=0, busy=0, err=0, and no done pulse occurs.
REQ-040 Simultaneous start and En in IDLE, mode=1, d=1 -> o=8'h00 and idx=0 after the edge. The first captured bit is the next cycle's d.
